// File: rtl/riscv_pkg.sv
// riscv_pkg: shared frontend widths and the fetch-queue entry layout.
package riscv_pkg;
    localparam int FRONTEND_WIDTH = 2;
    localparam int XLEN = 32;
    localparam int FQ_DEPTH = 8;
    localparam int FW_CNT_W = $clog2(FRONTEND_WIDTH + 1);

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fq_entry_t;
endpackage

// File: rtl/fetch_queue_popcount.sv
// fq_popcount: number of set bits in a FRONTEND_WIDTH-bit lane mask.
module fq_popcount
    import riscv_pkg::*;
(
    input  logic [FRONTEND_WIDTH-1:0] mask_i,
    output logic [FW_CNT_W-1:0]       count_o
);
    always_comb begin
        count_o = '0;
        for (int i = 0; i < FRONTEND_WIDTH; i++) count_o = count_o + FW_CNT_W'(mask_i[i]);
    end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction buffer between fetch and decode.
// Outputs depend only on registered state; pushes become visible one cycle later.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                flush_i,
    input  logic [FRONTEND_WIDTH-1:0]           if_valid_i,
    input  logic [FRONTEND_WIDTH-1:0][XLEN-1:0] if_instr_i,
    input  logic [FRONTEND_WIDTH-1:0][XLEN-1:0] if_pc_i,
    output logic                                if_ready_o,
    output logic [FRONTEND_WIDTH-1:0]           dec_valid_o,
    output logic [FRONTEND_WIDTH-1:0][XLEN-1:0] dec_instr_o,
    output logic [FRONTEND_WIDTH-1:0][XLEN-1:0] dec_pc_o,
    input  logic                                dec_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]          count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fq_entry_t         mem_q [DEPTH];
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d, navail;
    logic [FW_CNT_W-1:0] push_cnt, pop_cnt, npush, npop;
    logic              push_en;

    fq_popcount u_push_cnt (.mask_i(if_valid_i),  .count_o(push_cnt));
    fq_popcount u_pop_cnt  (.mask_i(dec_valid_o), .count_o(pop_cnt));

    // Readiness ignores a same-cycle pop so occupancy can never exceed DEPTH.
    assign if_ready_o = count_q <= CW'(DEPTH - FRONTEND_WIDTH);
    assign navail     = count_q < CW'(FRONTEND_WIDTH) ? count_q : CW'(FRONTEND_WIDTH);
    assign npush      = if_ready_o ? push_cnt : '0;
    assign npop       = dec_ready_i ? pop_cnt : '0;
    assign push_en    = if_ready_o && !flush_i && !reset;
    assign count_o    = count_q;

    for (genvar k = 0; k < FRONTEND_WIDTH; k++) begin : g_lane
        fq_entry_t e;
        assign e              = mem_q[rd_ptr_q + PW'(k)];
        assign dec_valid_o[k] = CW'(k) < navail;
        assign dec_instr_o[k] = dec_valid_o[k] ? e.instr : '0;
        assign dec_pc_o[k]    = dec_valid_o[k] ? e.pc : '0;
    end

    always_comb begin
        rd_ptr_d = flush_i ? '0 : rd_ptr_q + PW'(npop);
        wr_ptr_d = flush_i ? '0 : wr_ptr_q + PW'(npush);
        count_d  = flush_i ? '0 : count_q + CW'(npush) - CW'(npop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < FRONTEND_WIDTH; k++)
            if (push_en && if_valid_i[k]) mem_q[wr_ptr_q + PW'(k)] <= '{instr: if_instr_i[k], pc: if_pc_i[k]};
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenario tests for fetch_queue with FRONTEND_WIDTH=2, DEPTH=8.
module tb_fetch_queue;
    import riscv_pkg::*;

    logic                                clk = 0;
    logic                                reset = 0;
    logic                                flush_i = 0;
    logic [FRONTEND_WIDTH-1:0]           if_valid_i = '0;
    logic [FRONTEND_WIDTH-1:0][XLEN-1:0] if_instr_i = '0;
    logic [FRONTEND_WIDTH-1:0][XLEN-1:0] if_pc_i = '0;
    logic                                if_ready_o;
    logic [FRONTEND_WIDTH-1:0]           dec_valid_o;
    logic [FRONTEND_WIDTH-1:0][XLEN-1:0] dec_instr_o;
    logic [FRONTEND_WIDTH-1:0][XLEN-1:0] dec_pc_o;
    logic                                dec_ready_i = 0;
    logic [3:0]                          count_o;
    int checks = 0;
    int errors = 0;

    fetch_queue #(.DEPTH(8)) dut (
        .clk(clk), .reset(reset), .flush_i(flush_i),
        .if_valid_i(if_valid_i), .if_instr_i(if_instr_i), .if_pc_i(if_pc_i),
        .if_ready_o(if_ready_o), .dec_valid_o(dec_valid_o), .dec_instr_o(dec_instr_o),
        .dec_pc_o(dec_pc_o), .dec_ready_i(dec_ready_i), .count_o(count_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        assert (!(if_valid_i[1] && !if_valid_i[0])) else $error("non-contiguous if_valid_i %b", if_valid_i);

    function automatic logic [31:0] ins(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0013;
    endfunction

    task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1);
        if_valid_i    = v;
        if_pc_i[0]    = pc0;
        if_pc_i[1]    = pc1;
        if_instr_i[0] = ins(pc0);
        if_instr_i[1] = ins(pc1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1;
        step();
        reset = 0;
        checks++;
        if (count_o !== 4'd0 || dec_valid_o !== 2'b00 || if_ready_o !== 1'b1 || dec_pc_o !== '0 || dec_instr_o !== '0) begin
            errors++;
            $display("FAIL reset: count=%0d valid=%b ready=%b pc=%h instr=%h, want 0 00 1 0 0",
                     count_o, dec_valid_o, if_ready_o, dec_pc_o, dec_instr_o);
        end
    endtask

    task automatic test_first_push();
        drive(2'b11, 32'h0, 32'h4);
        dec_ready_i = 0;
        step();
        drive(2'b00, 0, 0);
        checks++;
        if (count_o !== 4'd2 || dec_valid_o !== 2'b11) begin
            errors++;
            $display("FAIL first_push_cnt: count=%0d valid=%b, want 2 11", count_o, dec_valid_o);
        end
        checks++;
        if (dec_pc_o[1] !== 32'h4 || dec_pc_o[0] !== 32'h0 || dec_instr_o[0] !== ins(32'h0) || dec_instr_o[1] !== ins(32'h4)) begin
            errors++;
            $display("FAIL first_push_data: pc=%h instr=%h, want pc 00000004_00000000", dec_pc_o, dec_instr_o);
        end
    endtask

    task automatic test_fill();
        logic [3:0] exp_cnt [3] = '{4'd4, 4'd6, 4'd8};
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 32'h8 + 32'(8 * i), 32'hC + 32'(8 * i));
            step();
            checks++;
            if (count_o !== exp_cnt[i] || if_ready_o !== (i < 2)) begin
                errors++;
                $display("FAIL fill_%0d: count=%0d ready=%b, want %0d %b", i, count_o, if_ready_o, exp_cnt[i], i < 2);
            end
        end
        drive(2'b01, 32'h20, 32'h0);
        step();
        drive(2'b00, 0, 0);
        checks++;
        if (count_o !== 4'd8 || if_ready_o !== 1'b0 || dec_pc_o[0] !== 32'h0) begin
            errors++;
            $display("FAIL full_drop: count=%0d ready=%b pc0=%h, want 8 0 0", count_o, if_ready_o, dec_pc_o[0]);
        end
        dec_ready_i = 1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dec_valid_o !== 2'b11 || dec_pc_o[0] !== 32'(8 * i) || dec_pc_o[1] !== 32'(8 * i + 4)) begin
                errors++;
                $display("FAIL drain_%0d: valid=%b pc=%h, want 11 pc0=%h", i, dec_valid_o, dec_pc_o, 8 * i);
            end
            step();
        end
        dec_ready_i = 0;
        checks++;
        if (count_o !== 4'd0 || dec_valid_o !== 2'b00) begin
            errors++;
            $display("FAIL drain_empty: count=%0d valid=%b, want 0 00", count_o, dec_valid_o);
        end
    endtask

    task automatic test_partial();
        drive(2'b01, 32'h100, 32'h0);
        step();
        drive(2'b00, 0, 0);
        checks++;
        if (count_o !== 4'd1 || dec_valid_o !== 2'b01 || dec_pc_o[0] !== 32'h100 || dec_pc_o[1] !== 32'h0) begin
            errors++;
            $display("FAIL partial: count=%0d valid=%b pc=%h, want 1 01 00000000_00000100", count_o, dec_valid_o, dec_pc_o);
        end
        dec_ready_i = 1;
        step();
        dec_ready_i = 0;
        checks++;
        if (count_o !== 4'd0 || dec_valid_o !== 2'b00) begin
            errors++;
            $display("FAIL partial_pop: count=%0d valid=%b, want 0 00", count_o, dec_valid_o);
        end
    endtask

    task automatic test_steady();
        drive(2'b11, 32'h1000, 32'h1004);
        step();
        checks++;
        if (count_o !== 4'd2) begin
            errors++;
            $display("FAIL steady_prefill: count=%0d, want 2", count_o);
        end
        dec_ready_i = 1;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (dec_valid_o !== 2'b11 || dec_pc_o[0] !== 32'h1000 + 32'(8 * i) || dec_pc_o[1] !== 32'h1004 + 32'(8 * i)
                || dec_instr_o[1] !== ins(32'h1004 + 32'(8 * i))) begin
                errors++;
                $display("FAIL steady_out_%0d: valid=%b pc=%h, want pc0=%h", i, dec_valid_o, dec_pc_o, 32'h1000 + 8 * i);
            end
            drive(2'b11, 32'h1008 + 32'(8 * i), 32'h100C + 32'(8 * i));
            step();
            checks++;
            if (count_o !== 4'd2) begin
                errors++;
                $display("FAIL steady_cnt_%0d: count=%0d, want 2", i, count_o);
            end
        end
        drive(2'b00, 0, 0);
        step();
        dec_ready_i = 0;
        checks++;
        if (count_o !== 4'd0) begin
            errors++;
            $display("FAIL steady_drain: count=%0d, want 0", count_o);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 32'h40 + 32'(8 * i), 32'h44 + 32'(8 * i));
            step();
        end
        checks++;
        if (count_o !== 4'd6) begin
            errors++;
            $display("FAIL flush_fill: count=%0d, want 6", count_o);
        end
        drive(2'b11, 32'h200, 32'h204);
        flush_i = 1;
        step();
        flush_i = 0;
        checks++;
        if (count_o !== 4'd0 || dec_valid_o !== 2'b00 || if_ready_o !== 1'b1 || dec_pc_o !== '0) begin
            errors++;
            $display("FAIL flush: count=%0d valid=%b ready=%b pc=%h, want 0 00 1 0", count_o, dec_valid_o, if_ready_o, dec_pc_o);
        end
        drive(2'b01, 32'h300, 32'h0);
        step();
        drive(2'b00, 0, 0);
        checks++;
        if (count_o !== 4'd1 || dec_valid_o !== 2'b01 || dec_pc_o[0] !== 32'h300 || dec_instr_o[0] !== ins(32'h300)) begin
            errors++;
            $display("FAIL flush_after: count=%0d valid=%b pc0=%h, want 1 01 00000300", count_o, dec_valid_o, dec_pc_o[0]);
        end
    endtask

    task automatic test_mid_reset();
        drive(2'b11, 32'h304, 32'h308);
        step();
        checks++;
        if (count_o !== 4'd3 || dec_pc_o[1] !== 32'h304) begin
            errors++;
            $display("FAIL midreset_fill: count=%0d pc1=%h, want 3 00000304", count_o, dec_pc_o[1]);
        end
        drive(2'b11, 32'h30C, 32'h310);
        dec_ready_i = 1;
        reset = 1;
        step();
        reset = 0;
        dec_ready_i = 0;
        drive(2'b00, 0, 0);
        checks++;
        if (count_o !== 4'd0 || dec_valid_o !== 2'b00 || if_ready_o !== 1'b1 || dec_pc_o !== '0 || dec_instr_o !== '0) begin
            errors++;
            $display("FAIL midreset: count=%0d valid=%b ready=%b pc=%h instr=%h, want 0 00 1 0 0",
                     count_o, dec_valid_o, if_ready_o, dec_pc_o, dec_instr_o);
        end
    endtask

    initial begin
        test_reset();
        test_first_push();
        test_fill();
        test_partial();
        test_steady();
        test_flush();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
